inst_prefetch_queue: RTL and testbench
======================================

Name: inst_prefetch_queue

Overview:
- Parametrised successor to the single-request instruction issuer.
- Keeps up to MAX_OUTSTANDING fetch requests in flight, buffers returned instructions in a QUEUE_DEPTH ring, and hands them to IF/ID in order.
- On a branch-mispredict redirect it flushes the queue and discards in-flight responses by count. No address compare is used for this.
- Sits between the branch-resolution redirect path, the instruction memory port and the IF/ID stage.

Parameters:
- XLEN, 32, address width.
- ILEN, 32, instruction width.
- QUEUE_DEPTH, 16, ring entries; power of 2, at least 2.
- MAX_OUTSTANDING, 2, maximum fetches in flight (live plus stale); at least 1.
- ID_WIDTH, 64, instruction-id counter width.
- PC_STEP, 4, sequential fetch increment.
- RESET_PC, 32'h0, first fetch address.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- redirect_valid  in  1  mispredict; restart fetch at redirect_addr
- redirect_addr  in  XLEN  new fetch pc
- mem_req_valid  out  1  fetch request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  XLEN  fetch address
- mem_resp_valid  in  1  fetch data returned; responses arrive in order, with no backpressure
- mem_resp_addr  in  XLEN  address of returned word
- mem_resp_inst  in  ILEN  returned instruction
- deq_valid  out  1  head entry available to IF/ID
- deq_ready  in  1  IF/ID consumes head
- deq_addr  out  XLEN  pc of head entry
- deq_inst  out  ILEN  instruction of head entry
- deq_inst_id  out  ID_WIDTH  id of head entry
- stale_drops  out  16  saturating count of discarded responses (debug)

Behaviour:
- Reset (async assert, sync release) clears state:
  - pc=RESET_PC; head=tail=0; count=0; live=0; stale=0; inst_id=0; stale_drops=0.
  - Outputs: mem_req_valid=0, deq_valid=0.
- Widths:
  - head and tail are clog2(QUEUE_DEPTH) bits and wrap naturally.
  - count is clog2(QUEUE_DEPTH)+1 bits.
  - live and stale are clog2(MAX_OUTSTANDING)+1 bits.
- Issue:
  - mem_req_valid = !redirect_valid && (live+stale) < MAX_OUTSTANDING && (count+live) < QUEUE_DEPTH.
  - mem_req_addr = pc.
  - On mem_req_valid && mem_req_ready: pc += PC_STEP (mod 2^XLEN) and live++.
- Response, with no redirect this cycle:
  - If stale != 0: drop the word, stale--, stale_drops++ (saturating at 16'hFFFF).
  - Otherwise: write {mem_resp_addr, mem_resp_inst} at tail, tail++, count++, live--.
  - Assertion: a live response's addr equals the oldest live request's addr.
- Dequeue:
  - deq_valid = count != 0 && !redirect_valid; deq_* show the entry at head.
  - On deq_valid && deq_ready: head++, count--, inst_id++.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full: the credit rule guarantees a push is never made with count == QUEUE_DEPTH; assert this.
- Empty: deq_valid=0; deq_* contents are don't-care.
- Redirect (redirect_valid=1), which has priority over everything:
  - pc <= redirect_addr; head <= tail; count <= 0; inst_id++.
  - stale <= stale + live − (mem_resp_valid ? 1 : 0); live <= 0.
  - The same-cycle response is dropped and counted in stale_drops.
  - No request is issued and no dequeue happens this cycle.
  - The first request to redirect_addr is issued in the next cycle, if credit allows.
- Back-to-back redirects: each one re-applies the redirect rules above. stale accumulates, bounded by MAX_OUTSTANDING.
- Request timing: mem_req_valid is held, with a stable address, until accepted. Only a redirect may withdraw it; memory acts on the handshake only.
- Reset mid-operation: all in-flight state is forgotten. The memory system shares rst_n, so no late responses are expected.
- Latency: a memory response becomes visible on deq_valid the cycle after mem_resp_valid. There is no combinational path from mem_resp_* to deq_*.

Decomposition:
- Shared fetch package holds:
  - fetch_entry_t {addr[XLEN], inst[ILEN]}.
  - Default constants: RESET_PC, PC_STEP.
  - The existing IRequest/IResponse types, for wrapper adaptation.
- Sub-module fetch_ring_buffer:
  - Parametrised in depth and entry type, with push, pop and flush ports.
  - Outputs: count, full, empty.
  - Owns head, tail and the storage array.

Test Plan:
- Reset release, deq_ready=1, memory latency 1 -> requests issued to 0x0, 0x4, 0x8 …; deq yields addr 0x0 with id 0, then 0x4 with id 1, in order.
- deq_ready=0 with QUEUE_DEPTH=4 -> exactly 4 entries fill; mem_req_valid stays 0 while count+live == 4; one dequeue re-enables exactly one request.
- MAX_OUTSTANDING=2 and memory latency 5 -> never more than 2 handshakes without a response in between; throughput is 2 per 5 cycles.
- Two requests in flight (0x10, 0x14), then redirect to 0x100 -> the 0x10 and 0x14 responses are dropped and stale_drops=2; the next deq_addr is 0x100 and deq_inst_id equals the prior id + 1.
- Redirect in the same cycle as mem_resp_valid plus a pending deq -> no push and no pop; the response is counted as dropped; count=0 on the next cycle.
- Queue wrap with QUEUE_DEPTH=4 over 20 sequential fetches with random deq_ready -> all 20 addrs are delivered in order with contiguous ids; the full and underflow assertions never fire. Asserting rst_n mid-stream clears all outputs immediately.

Source files
------------

// File: rtl/inst_prefetch_queue_pkg.sv
// Shared fetch-path types and defaults used by the prefetch queue and its wrappers.
package inst_prefetch_queue_pkg;

   localparam int unsigned FETCH_XLEN       = 32;
   localparam int unsigned FETCH_ILEN       = 32;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int unsigned DEFAULT_PC_STEP  = 4;

   // One buffered instruction: the pc it was fetched from and the word returned.
   typedef struct packed {
      logic [FETCH_XLEN-1:0] addr;
      logic [FETCH_ILEN-1:0] inst;
   } fetch_entry_t;

   // Request/response bundles of the single-request issuer, kept for wrapper adaptation.
   typedef struct packed {
      logic                  valid;
      logic [FETCH_XLEN-1:0] addr;
   } i_request_t;

   typedef struct packed {
      logic                  valid;
      logic [FETCH_XLEN-1:0] addr;
      logic [FETCH_ILEN-1:0] inst;
   } i_response_t;

   // Debug counters stick at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : (value + 16'd1);
   endfunction

endpackage

// File: rtl/fetch_ring_buffer.sv
// Power-of-two ring of fetched entries with push, pop and single-cycle flush.
// Flush discards everything by moving head onto tail; it wins over push/pop.
module fetch_ring_buffer
   import inst_prefetch_queue_pkg::*;
#(
   parameter int  DEPTH   = 16,
   parameter type entry_t = fetch_entry_t,
   localparam int AW      = $clog2(DEPTH),
   localparam int CW      = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  entry_t        push_data,
   input  logic          pop,
   output entry_t        head_data,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   entry_t        mem_r [DEPTH];
   logic [AW-1:0] head_r;
   logic [AW-1:0] tail_r;
   logic [CW-1:0] count_r;

   // Storage write; data needs no reset because count gates its visibility.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_r[tail_r] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else if (flush) begin
         head_r  <= tail_r;
         count_r <= '0;
      end else begin
         if (push) begin
            tail_r <= tail_r + AW'(1);
         end
         if (pop) begin
            head_r <= head_r + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Status and head-entry view.
   always_comb begin
      head_data = mem_r[head_r];
      count     = count_r;
      full      = (count_r == CW'(DEPTH));
      empty     = (count_r == '0);
   end

endmodule

// File: rtl/inst_prefetch_queue_sva.sv
// Protocol checks for the prefetch queue: no push into a full ring, no pop from an
// empty ring, and every kept response matches the oldest live request address.
module inst_prefetch_queue_sva #(
   parameter int XLEN    = 32,
   parameter int PC_STEP = 4,
   parameter int OW      = 2
) (
   input logic            clk,
   input logic            rst_n,
   input logic            push,
   input logic            pop,
   input logic            full,
   input logic            empty,
   input logic            resp_valid,
   input logic            redirect,
   input logic [XLEN-1:0] resp_addr,
   input logic [XLEN-1:0] pc,
   input logic [OW-1:0]   live,
   input logic [OW-1:0]   stale
);

   logic [XLEN-1:0] oldest_live_addr_s;

   // Live requests since the last redirect are sequential and end just below pc.
   always_comb begin
      oldest_live_addr_s = pc - (XLEN'(live) * XLEN'(PC_STEP));
   end

   a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
      push |-> !full);

   a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
      pop |-> !empty);

   a_live_resp_addr: assert property (@(posedge clk) disable iff (!rst_n)
      (resp_valid && !redirect && (stale == '0)) |->
         ((live != '0) && (resp_addr == oldest_live_addr_s)));

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: keeps up to MAX_OUTSTANDING fetches in flight, buffers
// returned words in a ring and delivers them in order. A redirect flushes the ring and
// marks every in-flight fetch stale; stale responses are dropped by count.
module inst_prefetch_queue
   import inst_prefetch_queue_pkg::*;
#(
   parameter int              XLEN            = 32,
   parameter int              ILEN            = 32,
   parameter int              QUEUE_DEPTH     = 16,
   parameter int              MAX_OUTSTANDING = 2,
   parameter int              ID_WIDTH        = 64,
   parameter int              PC_STEP         = DEFAULT_PC_STEP,
   parameter logic [XLEN-1:0] RESET_PC        = XLEN'(DEFAULT_RESET_PC)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                redirect_valid,
   input  logic [XLEN-1:0]     redirect_addr,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [XLEN-1:0]     mem_req_addr,
   input  logic                mem_resp_valid,
   input  logic [XLEN-1:0]     mem_resp_addr,
   input  logic [ILEN-1:0]     mem_resp_inst,
   output logic                deq_valid,
   input  logic                deq_ready,
   output logic [XLEN-1:0]     deq_addr,
   output logic [ILEN-1:0]     deq_inst,
   output logic [ID_WIDTH-1:0] deq_inst_id,
   output logic [15:0]         stale_drops
);

   localparam int QAW = $clog2(QUEUE_DEPTH);
   localparam int CW  = QAW + 1;
   localparam int OW  = $clog2(MAX_OUTSTANDING) + 1;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [ILEN-1:0] inst;
   } entry_t;

   logic [XLEN-1:0]     pc_r;
   logic [OW-1:0]       live_r;
   logic [OW-1:0]       stale_r;
   logic [ID_WIDTH-1:0] inst_id_r;
   logic [15:0]         stale_drops_r;

   logic [CW-1:0]       count_s;
   logic                full_s;
   logic                empty_s;
   entry_t              head_entry_s;
   entry_t              push_entry_s;

   logic                credit_s;
   logic                issue_fire_s;
   logic                resp_keep_s;
   logic                resp_drop_s;
   logic                deq_fire_s;
   logic [OW-1:0]       live_nxt_s;
   logic [OW-1:0]       stale_nxt_s;

   // Credit check and handshake decode. Credit counts both in-flight fetches and
   // ring slots already promised to live fetches, so the ring can never overflow.
   always_comb begin
      credit_s = ((32'(live_r) + 32'(stale_r)) < 32'(MAX_OUTSTANDING)) &&
                 ((32'(count_s) + 32'(live_r)) < 32'(QUEUE_DEPTH));
      mem_req_valid = rst_n && !redirect_valid && credit_s;
      mem_req_addr  = pc_r;
      issue_fire_s  = mem_req_valid && mem_req_ready;
      resp_keep_s   = mem_resp_valid && !redirect_valid && (stale_r == '0);
      resp_drop_s   = mem_resp_valid && (redirect_valid || (stale_r != '0));
      deq_valid     = !empty_s && !redirect_valid;
      deq_fire_s    = deq_valid && deq_ready;
      deq_addr      = head_entry_s.addr;
      deq_inst      = head_entry_s.inst;
      deq_inst_id   = inst_id_r;
      stale_drops   = stale_drops_r;
      push_entry_s  = '{addr: mem_resp_addr, inst: mem_resp_inst};
   end

   // In-flight accounting: a redirect turns all live fetches stale, less the one
   // answered in the same cycle.
   always_comb begin
      live_nxt_s  = live_r;
      stale_nxt_s = stale_r;
      if (redirect_valid) begin
         live_nxt_s  = '0;
         stale_nxt_s = stale_r + live_r - OW'(mem_resp_valid);
      end else begin
         live_nxt_s  = live_r + OW'(issue_fire_s) - OW'(resp_keep_s);
         stale_nxt_s = stale_r - OW'(resp_drop_s);
      end
   end

   // Fetch pc, in-flight counters, instruction id and drop counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r          <= RESET_PC;
         live_r        <= '0;
         stale_r       <= '0;
         inst_id_r     <= '0;
         stale_drops_r <= 16'h0000;
      end else begin
         live_r  <= live_nxt_s;
         stale_r <= stale_nxt_s;
         if (redirect_valid) begin
            pc_r <= redirect_addr;
         end else if (issue_fire_s) begin
            pc_r <= pc_r + XLEN'(PC_STEP);
         end
         if (redirect_valid || deq_fire_s) begin
            inst_id_r <= inst_id_r + ID_WIDTH'(1);
         end
         if (resp_drop_s) begin
            stale_drops_r <= sat_inc16(stale_drops_r);
         end
      end
   end

   fetch_ring_buffer #(
      .DEPTH   (QUEUE_DEPTH),
      .entry_t (entry_t)
   ) u_ring (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (resp_keep_s),
      .push_data (push_entry_s),
      .pop       (deq_fire_s),
      .head_data (head_entry_s),
      .count     (count_s),
      .full      (full_s),
      .empty     (empty_s)
   );

   inst_prefetch_queue_sva #(
      .XLEN    (XLEN),
      .PC_STEP (PC_STEP),
      .OW      (OW)
   ) u_sva (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (resp_keep_s),
      .pop        (deq_fire_s),
      .full       (full_s),
      .empty      (empty_s),
      .resp_valid (mem_resp_valid),
      .redirect   (redirect_valid),
      .resp_addr  (mem_resp_addr),
      .pc         (pc_r),
      .live       (live_r),
      .stale      (stale_r)
   );

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Randomized bench for inst_prefetch_queue with an in-order memory model and a
// transaction-level reference: fetches are tagged with the redirect epoch they were
// issued in, and only current-epoch responses reach the expected delivery queue.
module tb_inst_prefetch_queue;

   localparam int DEPTH   = 4;
   localparam int MAX_OUT = 2;
   localparam int NCYC    = 3000;
   localparam int RST_AT  = 2000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_addr;
   logic [31:0] mem_resp_inst;
   logic        deq_valid;
   logic        deq_ready;
   logic [31:0] deq_addr;
   logic [31:0] deq_inst;
   logic [63:0] deq_inst_id;
   logic [15:0] stale_drops;

   inst_prefetch_queue #(
      .QUEUE_DEPTH     (DEPTH),
      .MAX_OUTSTANDING (MAX_OUT)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_addr  (mem_resp_addr),
      .mem_resp_inst  (mem_resp_inst),
      .deq_valid      (deq_valid),
      .deq_ready      (deq_ready),
      .deq_addr       (deq_addr),
      .deq_inst       (deq_inst),
      .deq_inst_id    (deq_inst_id),
      .stale_drops    (stale_drops)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int unsigned epoch;
      int unsigned due;
   } pend_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] inst;
   } item_t;

   pend_t       pend_q[$];
   item_t       exp_q[$];
   logic [31:0] m_pc;
   int unsigned m_epoch;
   logic [63:0] m_id;
   int unsigned m_drops;
   int unsigned last_due;
   int          n_cmp = 0;
   int          n_err = 0;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      pend_q.delete();
      exp_q.delete();
      m_pc     = 32'h0000_0000;
      m_epoch  = 0;
      m_id     = 64'd0;
      m_drops  = 0;
      last_due = 0;
   endtask

   task automatic drive_idle();
      redirect_valid = 1'b0;
      redirect_addr  = 32'h0000_0000;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_addr  = 32'h0000_0000;
      mem_resp_inst  = 32'h0000_0000;
      deq_ready      = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_req_valid"}, 64'(mem_req_valid), 64'd0);
      check_eq({tag, "_deq_valid"}, 64'(deq_valid), 64'd0);
      check_eq({tag, "_stale_drops"}, 64'(stale_drops), 64'd0);
   endtask

   initial begin
      int          redir_pct;
      int          deq_pct;
      int          lat_lo;
      int          lat_hi;
      int          live_n;
      int unsigned due;
      bit          exp_req;
      bit          exp_deq;
      pend_t       p;
      item_t       it;

      rst_n = 1'b0;
      drive_idle();
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      for (int c = 0; c < NCYC; c++) begin
         @(negedge clk);

         if (c == RST_AT) begin
            rst_n = 1'b0;
            drive_idle();
            #1;
            check_reset_outputs("mid_reset");
            repeat (2) @(negedge clk);
            check_reset_outputs("mid_reset_hold");
            model_reset();
            rst_n = 1'b1;
         end

         // Phase knobs: plain streaming, fill with a stalled consumer, long latency, then chaos.
         if (c < 400) begin
            redir_pct = 0;  deq_pct = 100; lat_lo = 1; lat_hi = 1;
         end else if (c < 800) begin
            redir_pct = 0;  deq_pct = 10;  lat_lo = 1; lat_hi = 3;
         end else if (c < 1200) begin
            redir_pct = 0;  deq_pct = 100; lat_lo = 5; lat_hi = 5;
         end else begin
            redir_pct = 6;  deq_pct = 60;  lat_lo = 1; lat_hi = 5;
         end

         redirect_valid = ($urandom_range(0, 99) < redir_pct);
         redirect_addr  = ($urandom_range(0, 1023) << 2);
         deq_ready      = ($urandom_range(0, 99) < deq_pct);
         mem_req_ready  = ($urandom_range(0, 3) != 0);
         if ((pend_q.size() != 0) && (pend_q[0].due <= c)) begin
            mem_resp_valid = 1'b1;
            mem_resp_addr  = pend_q[0].addr;
            mem_resp_inst  = inst_of(pend_q[0].addr);
         end else begin
            mem_resp_valid = 1'b0;
            mem_resp_addr  = $urandom;
            mem_resp_inst  = $urandom;
         end
         #1;

         // Expected outputs from the state before this cycle's edge.
         live_n = 0;
         foreach (pend_q[i]) begin
            if (pend_q[i].epoch == m_epoch) live_n++;
         end
         exp_req = !redirect_valid && (pend_q.size() < MAX_OUT) &&
                   ((exp_q.size() + live_n) < DEPTH);
         exp_deq = (exp_q.size() != 0) && !redirect_valid;

         check_eq("req_valid", 64'(mem_req_valid), 64'(exp_req));
         if (exp_req) check_eq("req_addr", 64'(mem_req_addr), 64'(m_pc));
         check_eq("deq_valid", 64'(deq_valid), 64'(exp_deq));
         if (exp_deq) begin
            check_eq("deq_addr", 64'(deq_addr), 64'(exp_q[0].addr));
            check_eq("deq_inst", 64'(deq_inst), 64'(exp_q[0].inst));
            check_eq("deq_id", deq_inst_id, m_id);
         end
         check_eq("stale_drops", 64'(stale_drops), 64'(m_drops));

         // Advance the reference across the coming edge.
         if (exp_deq && deq_ready) begin
            void'(exp_q.pop_front());
            m_id++;
         end
         if (mem_resp_valid) begin
            p = pend_q.pop_front();
            if (redirect_valid || (p.epoch != m_epoch)) begin
               if (m_drops < 65535) m_drops++;
            end else begin
               it.addr = p.addr;
               it.inst = inst_of(p.addr);
               exp_q.push_back(it);
            end
         end
         if (redirect_valid) begin
            exp_q.delete();
            m_epoch++;
            m_id++;
            m_pc = redirect_addr;
         end
         if (exp_req && mem_req_ready) begin
            due = c + $urandom_range(lat_lo, lat_hi);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            p.addr  = m_pc;
            p.epoch = m_epoch;
            p.due   = due;
            pend_q.push_back(p);
            m_pc = m_pc + 32'd4;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
